riscv_muldiv: RTL

Iterative RV32M/RV64M multiply-divide unit, parametrised in XLEN, sitting beside the single-cycle integer ALU in the EX stage. It accepts one M-extension operation per handshake and computes it over XLEN cycles with a shift-add multiplier or a restoring divider. It returns the result with its destination tag over a valid/ready handshake and supports a pipeline flush.

---
 rtl/riscv_muldiv_pkg.sv | 19 +
 rtl/riscv_muldiv_div_step.sv | 21 ++
 rtl/riscv_muldiv.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the iterative RV32M/RV64M multiply-divide unit.
package riscv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/riscv_muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module riscv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dividend_bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < divisor_i always holds, so the shifted value needs only one guard bit.
  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[XLEN];
  assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative M-extension unit: shift-add multiply / restoring divide, one bit per cycle.
import riscv_muldiv_pkg::*;

module riscv_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_num1,
  input  logic [XLEN-1:0]  i_num2,
  input  logic [TAG_W-1:0] i_rd,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_num,
  output logic [TAG_W-1:0] o_rd,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [TAG_W-1:0]      rd_q, rd_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       res_q, res_d;

  logic                  sgn1_op, sgn2_op, s1, s2;
  logic [XLEN-1:0]       mag1, mag2;
  logic                  div_zero, div_ovf;
  logic [XLEN-1:0]       step_rem;
  logic                  step_q;
  logic [2*XLEN-1:0]     acc_step, prod_fix;
  logic [XLEN-1:0]       quot_fix, rem_fix;

  assign sgn1_op  = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                    (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
  assign sgn2_op  = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign s1       = sgn1_op && i_num1[XLEN-1];
  assign s2       = sgn2_op && i_num2[XLEN-1];
  assign mag1     = s1 ? -i_num1 : i_num1;
  assign mag2     = s2 ? -i_num2 : i_num2;
  assign div_zero = i_funct3[2] && (i_num2 == '0);
  assign div_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                    (i_num1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_num2 == '1);

  riscv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i          (acc_q[2*XLEN-1:XLEN]),
    .divisor_i      (b_q),
    .dividend_bit_i (a_q[CNT_LAST - cnt_q]),
    .rem_o          (step_rem),
    .q_o            (step_q)
  );

  // Divide packs remainder in the upper half and shifts quotient bits into the lower half.
  always_comb begin
    if (op_q[2]) begin
      acc_step = {step_rem, acc_q[XLEN-2:0], step_q};
    end else if (b_q[cnt_q]) begin
      acc_step = acc_q + ({{XLEN{1'b0}}, a_q} << cnt_q);
    end else begin
      acc_step = acc_q;
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quot_fix = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid && !i_flush) begin
          op_d  = i_funct3;
          rd_d  = i_rd;
          a_d   = mag1;
          b_d   = mag2;
          acc_d = '0;
          cnt_d = '0;
          neg_d = (i_funct3 == F3_REM) ? s1 : (s1 ^ s2);
          if (div_zero) begin
            res_d   = i_funct3[1] ? i_num1 : '1;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            res_d   = i_funct3[1] ? '0 : i_num1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          unique case (op_q)
            F3_MUL:                      res_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             res_d = quot_fix;
            default:                     res_d = rem_fix;
          endcase
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE) && !i_rst;
  assign o_valid = (state_q == ST_DONE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_num   = res_q;
  assign o_rd    = rd_q;

endmodule
